refill_write_gen: RTL and testbench

Converts one cache-line refill from the memory read channel into a sequence of per-word data-array write requests for the data-array write arbiter. It drives the arbiter's low-priority input (port 1); store writes on port 0 always win. The block has a one-entry output buffer so that memory beats are never lost while the arbiter is busy with stores.

---
 rtl/refill_write_gen_pkg.sv | 22 ++
 rtl/refill_buf.sv | 32 +++
 rtl/refill_write_gen.sv | 123 ++++++++++++
 tb/tb_refill_write_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/refill_write_gen_pkg.sv
// Shared cache definitions for the refill write path: write-request field
// widths, line geometry and the refill FSM encoding.
package refill_write_gen_pkg;

    localparam int CACHE_BEATS  = 2;
    localparam int CACHE_DATA_W = 32;
    localparam int CACHE_SET_W  = 6;
    localparam int CACHE_WAYS   = 4;
    localparam int CACHE_MASK_W = CACHE_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } refill_state_t;

    // Beat counters must reach BEATS itself, not just BEATS-1.
    function automatic int cnt_w(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/refill_buf.sv
// One-entry pass-through buffer holding a refill word and its beat index.
// A push in the same cycle as a pop replaces the entry and keeps it full.
module refill_buf #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic [IDX_W-1:0]  push_idx,
    output logic              full,
    output logic [DATA_W-1:0] data,
    output logic [IDX_W-1:0]  idx
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
            idx  <= '0;
        end else if (push) begin
            full <= 1'b1;
            data <= push_data;
            idx  <= push_idx;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/refill_write_gen.sv
// Turns one cache-line refill from the memory read channel into per-word
// data-array write requests on the arbiter's low-priority port.
module refill_write_gen
    import refill_write_gen_pkg::*;
#(
    parameter int BEATS  = CACHE_BEATS,
    parameter int DATA_W = CACHE_DATA_W,
    parameter int SET_W  = CACHE_SET_W,
    parameter int WAYS   = CACHE_WAYS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_req_valid,
    output logic                io_req_ready,
    input  logic [SET_W-1:0]    io_req_bits_set,
    input  logic [WAYS-1:0]     io_req_bits_way,
    input  logic                io_mem_valid,
    output logic                io_mem_ready,
    input  logic [DATA_W-1:0]   io_mem_bits_data,
    input  logic                io_mem_bits_last,
    output logic                io_write_valid,
    input  logic                io_write_ready,
    output logic [DATA_W-1:0]   io_write_bits_data,
    output logic [SET_W-1:0]    io_write_bits_set,
    output logic [BEATS-1:0]    io_write_bits_blockSelOH,
    output logic [WAYS-1:0]     io_write_bits_way,
    output logic [DATA_W/8-1:0] io_write_bits_mask,
    output logic                io_busy,
    output logic                io_done,
    output logic                io_protoErr
);

    localparam int CW = cnt_w(BEATS);

    refill_state_t     state;
    logic [SET_W-1:0]  set_lat;
    logic [WAYS-1:0]   way_lat;
    logic [CW-1:0]     recv_cnt;
    logic [CW-1:0]     wr_cnt;
    logic              proto_err;

    logic              buf_full;
    logic [DATA_W-1:0] buf_data;
    logic [CW-1:0]     buf_idx;

    logic              in_fill;
    logic              mem_fire;
    logic              write_fire;

    assign in_fill    = (state == ST_FILL);
    assign write_fire = io_write_valid && io_write_ready;
    assign mem_fire   = io_mem_valid && io_mem_ready;

    // The buffer may refill in the same cycle it drains, giving one word per cycle.
    assign io_mem_ready   = in_fill && (recv_cnt != CW'(BEATS)) && (!buf_full || write_fire);
    assign io_write_valid = in_fill && buf_full;

    // Payload is zero whenever nothing is offered, so idle outputs are quiet.
    assign io_write_bits_data       = io_write_valid ? buf_data : '0;
    assign io_write_bits_set        = io_write_valid ? set_lat : '0;
    assign io_write_bits_way        = io_write_valid ? way_lat : '0;
    assign io_write_bits_blockSelOH = io_write_valid ? (BEATS'(1) << buf_idx) : '0;
    assign io_write_bits_mask       = io_write_valid ? {(DATA_W/8){1'b1}} : '0;

    assign io_req_ready = (state == ST_IDLE);
    assign io_busy      = (state != ST_IDLE);
    assign io_done      = (state == ST_DONE);
    assign io_protoErr  = proto_err;

    refill_buf #(
        .DATA_W (DATA_W),
        .IDX_W  (CW)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (mem_fire),
        .pop       (write_fire),
        .push_data (io_mem_bits_data),
        .push_idx  (recv_cnt),
        .full      (buf_full),
        .data      (buf_data),
        .idx       (buf_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            set_lat   <= '0;
            way_lat   <= '0;
            recv_cnt  <= '0;
            wr_cnt    <= '0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (io_req_valid) begin
                        set_lat  <= io_req_bits_set;
                        way_lat  <= io_req_bits_way;
                        recv_cnt <= '0;
                        wr_cnt   <= '0;
                        state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Beat count alone drives progress; 'last' is only checked.
                    if (mem_fire) begin
                        recv_cnt  <= recv_cnt + CW'(1);
                        proto_err <= io_mem_bits_last != (recv_cnt == CW'(BEATS - 1));
                    end
                    if (write_fire) begin
                        wr_cnt <= wr_cnt + CW'(1);
                        if (wr_cnt == CW'(BEATS - 1))
                            state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_refill_write_gen.sv
// Randomized bench for refill_write_gen: a transaction-level model tracks
// words accepted and written per refill and predicts every handshake.
module tb_refill_write_gen;

    localparam int BEATS  = 2;
    localparam int DATA_W = 32;
    localparam int SET_W  = 6;
    localparam int WAYS   = 4;
    localparam int MW     = DATA_W / 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              io_req_valid = 1'b0;
    logic              io_req_ready;
    logic [SET_W-1:0]  io_req_bits_set = '0;
    logic [WAYS-1:0]   io_req_bits_way = '0;
    logic              io_mem_valid = 1'b0;
    logic              io_mem_ready;
    logic [DATA_W-1:0] io_mem_bits_data = '0;
    logic              io_mem_bits_last = 1'b0;
    logic              io_write_valid;
    logic              io_write_ready = 1'b0;
    logic [DATA_W-1:0] io_write_bits_data;
    logic [SET_W-1:0]  io_write_bits_set;
    logic [BEATS-1:0]  io_write_bits_blockSelOH;
    logic [WAYS-1:0]   io_write_bits_way;
    logic [MW-1:0]     io_write_bits_mask;
    logic              io_busy;
    logic              io_done;
    logic              io_protoErr;

    int vectors = 0;
    int miscompares = 0;

    refill_write_gen #(
        .BEATS (BEATS), .DATA_W (DATA_W), .SET_W (SET_W), .WAYS (WAYS)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .io_req_valid             (io_req_valid),
        .io_req_ready             (io_req_ready),
        .io_req_bits_set          (io_req_bits_set),
        .io_req_bits_way          (io_req_bits_way),
        .io_mem_valid             (io_mem_valid),
        .io_mem_ready             (io_mem_ready),
        .io_mem_bits_data         (io_mem_bits_data),
        .io_mem_bits_last         (io_mem_bits_last),
        .io_write_valid           (io_write_valid),
        .io_write_ready           (io_write_ready),
        .io_write_bits_data       (io_write_bits_data),
        .io_write_bits_set        (io_write_bits_set),
        .io_write_bits_blockSelOH (io_write_bits_blockSelOH),
        .io_write_bits_way        (io_write_bits_way),
        .io_write_bits_mask       (io_write_bits_mask),
        .io_busy                  (io_busy),
        .io_done                  (io_done),
        .io_protoErr              (io_protoErr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".write_valid"}, io_write_valid, 0);
        check({tag, ".mem_ready"}, io_mem_ready, 0);
        check({tag, ".busy"}, io_busy, 0);
        check({tag, ".done"}, io_done, 0);
        check({tag, ".protoErr"}, io_protoErr, 0);
        check({tag, ".req_ready"}, io_req_ready, 1);
        check({tag, ".bits"}, {io_write_bits_data, io_write_bits_set, io_write_bits_blockSelOH,
                               io_write_bits_way, io_write_bits_mask}, 0);
    endtask

    // wr_mode: 0 = write_ready always high, 1 = random, 2 = 3-cycle stall on first buffered word.
    // bad_idx: beat whose 'last' flag is inverted (-1 for none).
    task automatic do_refill(input logic [SET_W-1:0] set, input logic [WAYS-1:0] way,
                             input int wr_mode, input bit mem_rand, input int bad_idx,
                             input bit abort, input bit fixed);
        logic [DATA_W-1:0] words [BEATS];
        int  sent = 0, written = 0, cyc = 0, waited = 0, stall_left = 3;
        bit  exp_proto = 0, done_seen = 0, exp_wv, exp_mr, exp_done, wf, mf;
        for (int i = 0; i < BEATS; i++)
            words[i] = fixed ? (32'hDEAD0001 + DATA_W'(i)) : $urandom;

        @(negedge clock);
        io_req_valid = 1'b1;
        io_req_bits_set = set;
        io_req_bits_way = way;
        #1;
        while (!io_req_ready && waited < 20) begin
            @(negedge clock);
            #1;
            waited++;
        end
        check("req_accept_wait", waited, 0);
        if (waited >= 20) begin
            io_req_valid = 1'b0;
            return;
        end

        while (!done_seen && cyc < 60) begin
            @(negedge clock);
            cyc++;
            io_req_valid = 1'b0;
            io_req_bits_set = SET_W'($urandom);
            io_req_bits_way = WAYS'($urandom);
            io_mem_valid = (sent < BEATS) && (!mem_rand || ($urandom_range(0, 1) == 1));
            io_mem_bits_data = (sent < BEATS) ? words[sent] : $urandom;
            io_mem_bits_last = ((sent == BEATS - 1) != (sent == bad_idx));
            case (wr_mode)
                0: io_write_ready = 1'b1;
                1: io_write_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    io_write_ready = 1'b1;
                    if (written == 0 && sent > 0 && stall_left > 0) begin
                        io_write_ready = 1'b0;
                        stall_left--;
                    end
                end
            endcase
            #1;
            exp_done = (written == BEATS);
            exp_wv   = (sent > written);
            exp_mr   = !exp_done && (sent < BEATS) && (sent == written || (exp_wv && io_write_ready));
            check("done", io_done, exp_done);
            check("busy", io_busy, 1);
            check("req_ready", io_req_ready, 0);
            check("protoErr", io_protoErr, exp_proto);
            check("write_valid", io_write_valid, exp_wv);
            check("mem_ready", io_mem_ready, exp_mr);
            if (exp_wv) begin
                check("wr_data", io_write_bits_data, words[written]);
                check("wr_blockSelOH", io_write_bits_blockSelOH, BEATS'(1) << written);
                check("wr_set", io_write_bits_set, set);
                check("wr_way", io_write_bits_way, way);
                check("wr_mask", io_write_bits_mask, {MW{1'b1}});
            end
            wf = exp_wv && io_write_ready;
            mf = io_mem_valid && exp_mr;
            exp_proto = mf && (io_mem_bits_last != (sent == BEATS - 1));
            if (exp_done) begin
                done_seen = 1;
                if (wr_mode == 0 && !mem_rand) check("fill_cycles", cyc, 4);
                if (wr_mode == 2 && !mem_rand) check("stall_cycles", cyc, 7);
            end
            if (wf) written++;
            if (mf) sent++;
            if (abort && wf) begin
                @(posedge clock);
                #1;
                io_mem_valid = 1'b0;
                io_write_ready = 1'b0;
                reset = 1'b1;
                #1;
                check_idle("abort");
                @(negedge clock);
                reset = 1'b0;
                return;
            end
        end
        if (!done_seen) check("done_timeout", 0, 1);
    endtask

    initial begin
        #2;
        check_idle("reset");
        #20;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_idle("post_reset");

        // Basic refill, then stall, protocol error; consecutive calls are back-to-back.
        do_refill(6'h15, 4'b0100, 0, 0, -1, 0, 1);
        do_refill(6'h2A, 4'b0001, 2, 0, -1, 0, 0);
        do_refill(6'h07, 4'b1000, 0, 0, 0, 0, 0);
        do_refill(6'h3F, 4'b0010, 0, 0, -1, 1, 0);
        do_refill(6'h01, 4'b0010, 0, 0, -1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            do_refill(SET_W'($urandom), WAYS'(1) << $urandom_range(0, WAYS - 1),
                      $urandom_range(0, 2), $urandom_range(0, 1) == 1,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, BEATS - 1) : -1,
                      $urandom_range(0, 7) == 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
